mem_port_arbiter: RTL and testbench

// Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-memory port.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sharing one single-port unified memory
// One transaction outstanding at a time: IDLE grants, ISSUE holds the command, WAIT routes the response.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [DATA_W/8-1:0] i_dm_be,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic                o_dm_gnt,
  output logic                o_dm_rvalid,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy,
  output logic                o_proto_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbStateT;

  arbStateT           state;
  arbStateT           nextState;
  logic               ownerDm;
  logic [CNT_W-1:0]   starveCnt;
  logic               starved;
  logic               ifWins;
  logic               dmWins;

  // DM normally wins; a fetch that has watched STARVE_MAX DM grants go by takes the next slot.
  always_comb begin
    starved   = (starveCnt == CNT_W'(STARVE_MAX));
    ifWins    = i_if_req && (!i_dm_req || starved);
    dmWins    = i_dm_req && !ifWins;
    o_if_gnt  = 1'b0;
    o_dm_gnt  = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        o_if_gnt = ifWins && !rst;
        o_dm_gnt = dmWins && !rst;
        if (ifWins || dmWins) nextState = ISSUE;
      end
      ISSUE: if (i_mem_ready) nextState = WAIT;
      WAIT:  if (i_mem_rvalid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_dm_rvalid <= 1'b0;
      o_dm_rdata  <= '0;
      o_proto_err <= 1'b0;
      ownerDm     <= 1'b0;
      starveCnt   <= '0;
    end else begin
      o_if_rvalid <= 1'b0;
      o_dm_rvalid <= 1'b0;
      // A response with no transaction waiting for it means the memory broke its contract.
      if (i_mem_rvalid && state != WAIT) o_proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (o_if_gnt) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '1;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
            ownerDm     <= 1'b0;
            starveCnt   <= '0;
          end else if (o_dm_gnt) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_dm_we;
            o_mem_be    <= i_dm_be;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
            ownerDm     <= 1'b1;
            if (!i_if_req)    starveCnt <= '0;
            else if (!starved) starveCnt <= starveCnt + CNT_W'(1);
          end
        end
        ISSUE: begin
          if (i_mem_ready) o_mem_req <= 1'b0;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            if (ownerDm) begin
              o_dm_rvalid <= 1'b1;
              o_dm_rdata  <= o_mem_we ? '0 : i_mem_rdata;
            end else begin
              o_if_rvalid <= 1'b1;
              o_if_rdata  <= i_mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [3:0]  i_dm_be;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic        o_dm_gnt;
  logic        o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_proto_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt),
    .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_be = 4'h0; i_dm_addr = 32'h0; i_dm_wdata = 32'h0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    tick(); tick(); #1;
    checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {o_if_gnt, o_dm_gnt}); end
    checks++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== 70'h0) begin errors++; $display("FAIL reset_mem got %0h exp 0", {o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}); end
    checks++; if ({o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, o_proto_err, o_busy} !== 68'h0) begin errors++; $display("FAIL reset_resp got %0h exp 0", {o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, o_proto_err, o_busy}); end
    tick();
    i_if_req = 1'b0; i_dm_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_dm_load();
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h100; #1;
    checks++; if ({o_dm_gnt, o_if_gnt} !== 2'b10) begin errors++; $display("FAIL load_gnt_c0 got %b exp 10", {o_dm_gnt, o_if_gnt}); end
    tick();
    i_dm_req = 1'b0; i_mem_ready = 1'b1; #1;
    checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL load_issue_c1 got %0h exp %0h", {o_mem_req, o_mem_we, o_mem_addr}, {2'b10, 32'h100}); end
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF; #1;
    checks++; if ({o_mem_req, o_dm_rvalid, o_busy} !== 3'b001) begin errors++; $display("FAIL load_wait_c2 got %b exp 001", {o_mem_req, o_dm_rvalid, o_busy}); end
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_dm_rvalid, o_dm_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL load_rvalid_c3 got %0h exp %0h", {o_dm_rvalid, o_dm_rdata}, {1'b1, 32'hDEADBEEF}); end
    checks++; if ({o_if_rvalid, o_if_rdata, o_busy} !== 34'h0) begin errors++; $display("FAIL load_if_side_c3 got %0h exp 0", {o_if_rvalid, o_if_rdata, o_busy}); end
    tick(); #1;
    checks++; if ({o_dm_rvalid, o_dm_rdata} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL load_pulse_c4 got %0h exp %0h", {o_dm_rvalid, o_dm_rdata}, {1'b0, 32'hDEADBEEF}); end
  endtask

  task automatic test_priority();
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h104;
    i_if_req = 1'b1; i_if_addr = 32'h2000; #1;
    checks++; if ({o_dm_gnt, o_if_gnt} !== 2'b10) begin errors++; $display("FAIL prio_gnt_c0 got %b exp 10", {o_dm_gnt, o_if_gnt}); end
    tick();
    i_dm_req = 1'b0; i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAAAA0000; #1;
    checks++; if (o_if_gnt !== 1'b0) begin errors++; $display("FAIL prio_if_early_c2 got %b exp 0", o_if_gnt); end
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_if_gnt, o_dm_rvalid, o_dm_rdata} !== {2'b11, 32'hAAAA0000}) begin errors++; $display("FAIL prio_if_gnt_c3 got %0h exp %0h", {o_if_gnt, o_dm_rvalid, o_dm_rdata}, {2'b11, 32'hAAAA0000}); end
    tick();
    i_if_req = 1'b0; i_mem_ready = 1'b1; #1;
    checks++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr} !== {2'b10, 4'hF, 32'h2000}) begin errors++; $display("FAIL prio_fetch_cmd got %0h exp %0h", {o_mem_req, o_mem_we, o_mem_be, o_mem_addr}, {2'b10, 4'hF, 32'h2000}); end
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h00000013;
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_if_rvalid, o_if_rdata, o_dm_rvalid} !== {1'b1, 32'h13, 1'b0}) begin errors++; $display("FAIL prio_fetch_resp got %0h exp %0h", {o_if_rvalid, o_if_rdata, o_dm_rvalid}, {1'b1, 32'h13, 1'b0}); end
  endtask

  task automatic test_starvation();
    logic prevDm;
    prevDm = 1'b0;
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h108;
    i_if_req = 1'b1; i_if_addr = 32'h2004;
    i_mem_rdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      logic expDm;
      expDm = (k != 4);
      #1;
      checks++; if ({o_dm_gnt, o_if_gnt} !== {expDm, ~expDm}) begin errors++; $display("FAIL starve_gnt_%0d got %b exp %b", k, {o_dm_gnt, o_if_gnt}, {expDm, ~expDm}); end
      if (k > 0) begin
        checks++; if ({o_dm_rvalid, o_if_rvalid} !== {prevDm, ~prevDm}) begin errors++; $display("FAIL starve_rvalid_%0d got %b exp %b", k, {o_dm_rvalid, o_if_rvalid}, {prevDm, ~prevDm}); end
      end
      prevDm = expDm;
      tick();
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b1;
      tick();
      i_mem_rvalid = 1'b0;
    end
    i_dm_req = 1'b0; i_if_req = 1'b0;
    tick(); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL starve_idle got %b exp 0", o_busy); end
  endtask

  task automatic test_store_stall();
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_be = 4'h3; i_dm_addr = 32'h200; i_dm_wdata = 32'h12345678; #1;
    checks++; if (o_dm_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got %b exp 1", o_dm_gnt); end
    for (int c = 0; c < 6; c++) begin
      tick();
      i_dm_req = 1'b0; i_dm_wdata = 32'hFFFF0000; i_dm_be = 4'hC;
      i_mem_ready = (c == 5); #1;
      checks++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== {2'b11, 4'h3, 32'h200, 32'h12345678}) begin errors++; $display("FAIL store_payload_%0d got %0h exp %0h", c, {o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, {2'b11, 4'h3, 32'h200, 32'h12345678}); end
    end
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF; #1;
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL store_req_drop got %b exp 0", o_mem_req); end
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_dm_rvalid, o_dm_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL store_ack got %0h exp %0h", {o_dm_rvalid, o_dm_rdata}, {1'b1, 32'h0}); end
  endtask

  task automatic test_reset_in_wait();
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_be = 4'hF; i_dm_addr = 32'h1F0;
    tick();
    i_dm_req = 1'b0; i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0; #1;
    checks++; if ({o_busy, o_mem_req} !== 2'b10) begin errors++; $display("FAIL rstwait_in_wait got %b exp 10", {o_busy, o_mem_req}); end
    rst = 1'b1; #1;
    checks++; if ({o_busy, o_mem_req, o_dm_gnt, o_if_gnt} !== 4'b0000) begin errors++; $display("FAIL rstwait_abandon got %b exp 0000", {o_busy, o_mem_req, o_dm_gnt, o_if_gnt}); end
    tick();
    rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBADBAD00;
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_dm_rvalid, o_if_rvalid, o_dm_rdata, o_proto_err} !== {2'b00, 32'h0, 1'b1}) begin errors++; $display("FAIL rstwait_late_rvalid got %0h exp %0h", {o_dm_rvalid, o_if_rvalid, o_dm_rdata, o_proto_err}, {2'b00, 32'h0, 1'b1}); end
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h300; #1;
    checks++; if (o_dm_gnt !== 1'b1) begin errors++; $display("FAIL rstwait_next_gnt got %b exp 1", o_dm_gnt); end
    tick();
    i_dm_req = 1'b0; i_mem_ready = 1'b1; #1;
    checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rstwait_next_cmd got %0h exp %0h", {o_mem_req, o_mem_addr}, {1'b1, 32'h300}); end
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55;
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if ({o_dm_rvalid, o_dm_rdata, o_proto_err} !== {1'b1, 32'h55, 1'b1}) begin errors++; $display("FAIL rstwait_next_resp got %0h exp %0h", {o_dm_rvalid, o_dm_rdata, o_proto_err}, {1'b1, 32'h55, 1'b1}); end
  endtask

  task automatic test_proto_err_idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_cleared got %b exp 0", o_proto_err); end
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77;
    tick();
    i_mem_rvalid = 1'b0; #1;
    checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", o_proto_err); end
    checks++; if ({o_busy, o_mem_req, o_dm_rvalid, o_if_rvalid, o_dm_rdata, o_if_rdata} !== 68'h0) begin errors++; $display("FAIL proto_others got %0h exp 0", {o_busy, o_mem_req, o_dm_rvalid, o_if_rvalid, o_dm_rdata, o_if_rdata}); end
    tick(); tick(); tick(); #1;
    checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", o_proto_err); end
  endtask

  initial begin
    test_reset();
    test_dm_load();
    test_priority();
    test_starvation();
    test_store_stall();
    test_reset_in_wait();
    test_proto_err_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
